aes_sub_bytes: RTL and testbench



---
 rtl/aes_sub_bytes.sv | 98 +++++++++
 tb/tb_aes_sub_bytes.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/aes_sub_bytes.sv
// AES SubBytes stage: forward S-box on all 16 bytes, registered output.
// Define SUB_BYTES_IN_REG_EN to add an input register stage (latency 2 instead of 1).
module aes_sub_bytes (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [127:0] state_in,
  output logic         out_valid,
  output logic [127:0] state_out
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
    end
    return p;
  endfunction

  // Inverse as x^254 (product of x^2..x^128); this maps 0 to 0 for free.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    logic [7:0] b;
    sq  = gf_mul(x, x);
    inv = sq;
    for (int k = 0; k < 6; k++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    b = inv;
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
             ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  logic         src_valid;
  logic [127:0] src_state;
  logic [127:0] sub_state;

`ifdef SUB_BYTES_IN_REG_EN
  logic         in_valid_q, in_valid_d;
  logic [127:0] state_in_q, state_in_d;

  always_comb begin
    in_valid_d = in_valid;
    state_in_d = in_valid ? state_in : state_in_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_valid_q <= 1'b0;
      state_in_q <= 128'h0;
    end else begin
      in_valid_q <= in_valid_d;
      state_in_q <= state_in_d;
    end
  end

  assign src_valid = in_valid_q;
  assign src_state = state_in_q;
`else
  assign src_valid = in_valid;
  assign src_state = state_in;
`endif

  always_comb begin
    sub_state = 128'h0;
    for (int i = 0; i < 16; i++) begin
      sub_state[8*i +: 8] = sbox(src_state[8*i +: 8]);
    end
  end

  logic         out_valid_q, out_valid_d;
  logic [127:0] state_out_q, state_out_d;

  always_comb begin
    out_valid_d = src_valid;
    state_out_d = src_valid ? sub_state : state_out_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      state_out_q <= 128'h0;
    end else begin
      out_valid_q <= out_valid_d;
      state_out_q <= state_out_d;
    end
  end

  assign out_valid = out_valid_q;
  assign state_out = state_out_q;

endmodule

// File: tb/tb_aes_sub_bytes.sv
// Self-checking bench for aes_sub_bytes against a brute-force GF(2^8) S-box model.
module tb_aes_sub_bytes;

`ifdef SUB_BYTES_IN_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic [127:0] state_in;
  logic         out_valid;
  logic [127:0] state_out;

  aes_sub_bytes dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .state_in  (state_in),
    .out_valid (out_valid),
    .state_out (state_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [7:0]   sbox_tbl [256];
  logic [128:0] hist [$];
  logic         exp_valid;
  logic [127:0] exp_state;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Carry-less polynomial product, then long division by x^8+x^4+x^3+x+1.
  function automatic logic [7:0] poly_mul_mod(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] prod;
    prod = 16'h0;
    for (int i = 0; i < 8; i++)
      if (b[i]) prod = prod ^ (16'(a) << i);
    for (int d = 15; d >= 8; d--)
      if (prod[d]) prod = prod ^ (16'h011b << (d - 8));
    return prod[7:0];
  endfunction

  function automatic logic [7:0] ref_sbox(input logic [7:0] x);
    logic [7:0] inv;
    logic [7:0] c;
    logic [7:0] s;
    inv = 8'h00;
    for (int y = 1; y < 256; y++)
      if (poly_mul_mod(x, 8'(y)) == 8'h01) inv = 8'(y);
    c = 8'h63;
    for (int i = 0; i < 8; i++)
      s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
    return s;
  endfunction

  function automatic logic [127:0] ref_state(input logic [127:0] s);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = sbox_tbl[s[8*i +: 8]];
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Called at a falling edge: drive, take one rising edge, check at the next falling edge.
  task automatic step(input logic v, input logic [127:0] s);
    int idx;
    in_valid = v;
    state_in = s;
    @(posedge clk);
    hist.push_back({v, s});
    idx = hist.size() - LAT;
    if (idx >= 0 && hist[idx][128]) begin
      exp_valid = 1'b1;
      exp_state = ref_state(hist[idx][127:0]);
    end else begin
      exp_valid = 1'b0;
    end
    @(negedge clk);
    check("out_valid", {127'h0, out_valid}, {127'h0, exp_valid});
    check("state_out", state_out, exp_state);
  endtask

  task automatic vector(input string tag, input logic [127:0] s, input logic [127:0] want);
    step(1'b1, s);
    for (int k = 1; k < LAT; k++) step(1'b0, rand128());
    check(tag, state_out, want);
    for (int k = 0; k < 3; k++) step(1'b0, rand128());
    check({tag, "_hold"}, state_out, want);
  endtask

  initial begin
    for (int x = 0; x < 256; x++) sbox_tbl[x] = ref_sbox(8'(x));
    exp_valid = 1'b0;
    exp_state = 128'h0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    state_in = 128'h0;
    #12;
    check("reset_valid", {127'h0, out_valid}, 128'h0);
    check("reset_state", state_out, 128'h0);
    @(negedge clk);
    rst_n = 1'b1;

    vector("fips",  128'h3243f6a8885a308d313198a2e0370734, 128'h231a42c2c4be045dc7c7463ae19ac518);
    vector("zeros", 128'h0, {16{8'h63}});
    vector("ones",  {128{1'b1}}, {16{8'h16}});
    vector("diag",  128'h00112233445566778899aabbccddeeff, 128'h638293c31bfc33f5c4eeacea4bc12816);
    vector("b53",   {16{8'h53}}, {16{8'hed}});
    vector("b01",   {16{8'h01}}, {16{8'h7c}});

    for (int x = 0; x < 256; x++) step(1'b1, {16{8'(x)}});
    for (int k = 0; k < LAT; k++) step(1'b0, rand128());

    for (int n = 0; n < 60; n++) step(1'($urandom_range(0, 1)), rand128());

    // Asynchronous reset mid-cycle with valid output and data still in flight.
    step(1'b1, rand128());
    step(1'b1, rand128());
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", {127'h0, out_valid}, 128'h0);
    check("async_rst_state", state_out, 128'h0);
    hist.delete();
    exp_valid = 1'b0;
    exp_state = 128'h0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) step(1'b0, rand128());
    for (int n = 0; n < 40; n++) step(1'($urandom_range(0, 1)), rand128());
    for (int k = 0; k < LAT + 1; k++) step(1'b0, rand128());

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
